stream_mux_nto1: RTL and testbench
==================================

// Module: stream_mux_nto1
// PURPOSE
//   Parametrised N:1 streaming multiplexer, successor to the gate-level 4:1 mux.
//   Selects one of N_CH valid/ready input channels, by software select or round-robin.
//   Holds the grant for a whole packet (until in_last) and drives one registered output stage.
//   Sits between per-channel producers and a single shared consumer (e.g. a serialiser or UART TX).
// PARAMETERS
//   N_CH    4   number of input channels, >= 2
//   DATA_W  8   data width per channel, >= 1
//   SEL_W   $clog2(N_CH)   derived localparam, not overridable; width of sel/out_ch
// PORTS
//   clk       in   1             single clock; all logic on rising edge
//   rst_n     in   1             synchronous, active-low reset
//   mode_rr   in   1             0 = manual select via sel, 1 = round-robin
//   sel       in   SEL_W         manual channel select; used only when mode_rr=0
//   in_data   in   N_CH*DATA_W   channel i occupies bits [i*DATA_W +: DATA_W]
//   in_valid  in   N_CH          per-channel valid
//   in_last   in   N_CH          per-channel end-of-packet flag, qualified by in_valid
//   in_ready  out  N_CH          per-channel ready, combinational
//   out_data  out  DATA_W        registered data
//   out_last  out  1             registered end-of-packet flag
//   out_ch    out  SEL_W         registered source channel of the current beat
//   out_valid out  1             registered valid
//   out_ready in   1             downstream ready
// BEHAVIOUR
//   Reset (rst_n=0 at clk edge):
//     - out_valid=0, out_data=0, out_last=0, out_ch=0, lock=0
//     - rr_ptr=N_CH-1, so ch0 has first priority
//     - in_ready is forced to all-0 while rst_n=0
//   Transfer rules:
//     - A transfer occurs on an edge where valid && ready, on either side.
//     - Output register may load when load_en = !out_valid || out_ready.
//     - Latency is 1 cycle from input accept to out_valid.
//     - Throughput is 1 beat/clk when out_ready is held high.
//     - out_* hold stable while out_valid && !out_ready.
//     - out_valid drops after an accepted output beat if no input was accepted that edge.
//   Grant (combinational, one-hot or none):
//     - lock=1: grant = locked channel, regardless of mode_rr or sel.
//     - Manual mode: grant = sel. If sel >= N_CH, there is no grant and in_ready = 0.
//     - RR mode: grant = first i with in_valid[i], searching rr_ptr+1, rr_ptr+2, ...
//       modulo N_CH (wraps). No valid channel means no grant.
//     - in_ready[i] = rst_n && grant==i && load_en.
//     - Non-granted channels see in_ready=0 and must hold their data.
//   Packet lock:
//     - Accepting a beat with in_last=0 sets lock=1 and stores the channel.
//     - Accepting a beat with in_last=1 clears lock. A single-beat packet never locks.
//     - rr_ptr updates to the granted channel on every accepted beat with in_last=1 only.
//     - Changes to mode_rr or sel while locked take effect after the packet ends.
//   Simultaneous events:
//     - Output drain and new accept on the same edge: register reloads and out_valid stays 1.
//     - Valid dropping on the locked channel mid-packet: the grant stays. No other channel
//       is served, so a lock can stall the mux by design.
//   Reset mid-packet: lock is cleared and any held output beat is discarded (out_valid=0).
//   No internal data arithmetic. The rr search index is computed in SEL_W+1 bits,
//   then reduced modulo N_CH, so non-power-of-2 N_CH wraps correctly.
// STRUCTURE
//   Package stream_mux_pkg:
//     - localparam function clog2_min1 (returns >= 1)
//     - MODE_MANUAL=1'b0 and MODE_RR=1'b1 constants
//   Sub-module rr_arbiter #(N_CH):
//     - inputs req[N_CH], ptr[SEL_W]; outputs gnt_vld, gnt_idx[SEL_W]
//     - purely combinational rotating-priority search
//     - everything else (lock, pointer, output register) lives in the top
// TESTING
//   1. Reset: rst_n=0 for 2 clks with all in_valid=1 -> in_ready=0, out_valid=0, out_ch=0;
//      ch0 is granted first after release in RR mode.
//   2. Manual mode, N_CH=4, DATA_W=8:
//      - in_data ch0..3 = 0x11,0x22,0x33,0x44, all valid/last=1, out_ready=1
//      - sel=0,1,2,3 on successive clks -> out_data 0x11,0x22,0x33,0x44 one clk later,
//        out_ch tracks sel
//   3. RR fairness: all 4 channels valid, single-beat packets, out_ready=1
//      -> out_ch sequence 0,1,2,3,0,1,... with no gaps.
//      Drop ch2 valid -> sequence 0,1,3,0,1,3.
//   4. Packet lock:
//      - ch1 sends 3 beats with last on the 3rd; ch0 and ch3 are valid throughout
//      - out_ch=1 for all 3 beats with no interleave; next grant goes to ch3
//      - toggling sel or mode_rr mid-packet has no effect
//   5. Backpressure: out_ready=0 for 5 clks with out_valid=1
//      -> out_data/out_last/out_ch stable, in_ready=0.
//      Release -> beats resume with none lost or duplicated.
//   6. Edge cases:
//      - N_CH=3, sel=3 in manual mode -> no grant, out_valid stays 0
//      - reset asserted mid-packet -> lock cleared and the next packet may come from
//        any channel

Source files
------------

// File: rtl/stream_mux_pkg.sv
// Shared definitions for the N:1 stream multiplexer.
//   clog2_min1  : select-index width helper, never returns less than 1
//   MODE_*      : values of the mode_rr input
//   mux_state_e : grant state of the mux, OPEN (free to arbitrate) or LOCKED (mid-packet)
package stream_mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  typedef enum logic {
    ST_OPEN   = 1'b0,
    ST_LOCKED = 1'b1
  } mux_state_e;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stream_mux_nto1_if.sv
// Bus bundle for stream_mux_nto1: control, N_CH input channels and one output stream.
//   mode_rr, sel                   : arbitration mode and manual select
//   in_data/in_valid/in_last       : per-channel producer side, in_ready back to producers
//   out_data/out_last/out_ch/out_valid : registered output stream, out_ready from consumer
// Handshake: a beat moves on a rising edge where valid and ready are both 1; a source
// holds its data and valid stable until that edge, and ready never depends on the
// same side's future state.
// Modports: slave = the mux, master = the environment driving channels and the consumer.
interface stream_mux_nto1_if
  import stream_mux_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int DATA_W = 8
);
  localparam int SEL_W = clog2_min1(N_CH);

  logic                     mode_rr;
  logic [SEL_W-1:0]         sel;
  logic [N_CH*DATA_W-1:0]   in_data;
  logic [N_CH-1:0]          in_valid;
  logic [N_CH-1:0]          in_last;
  logic [N_CH-1:0]          in_ready;
  logic [DATA_W-1:0]        out_data;
  logic                     out_last;
  logic [SEL_W-1:0]         out_ch;
  logic                     out_valid;
  logic                     out_ready;

  modport slave (
    input  mode_rr, sel, in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_last, out_ch, out_valid
  );

  modport master (
    output mode_rr, sel, in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_last, out_ch, out_valid
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority search.
//   req     : request vector, one bit per channel
//   ptr     : last served channel; search starts at ptr+1 and wraps modulo N_CH
//   gnt_vld : some request was found
//   gnt_idx : index of the first requesting channel after ptr
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter  int N_CH  = 4,
  localparam int SEL_W = clog2_min1(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic             gnt_vld,
  output logic [SEL_W-1:0] gnt_idx
);

  localparam logic [SEL_W:0] N_CH_X = (SEL_W+1)'(N_CH);

  // One extra bit so ptr+k never overflows before the wrap; a single subtract
  // is enough because ptr+k < 2*N_CH. Works for non-power-of-2 N_CH.
  logic [SEL_W:0] cand;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 1; k <= N_CH; k++) begin
      cand = {1'b0, ptr} + (SEL_W+1)'(k);
      if (cand >= N_CH_X) cand = cand - N_CH_X;
      if (!gnt_vld && req[cand[SEL_W-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand[SEL_W-1:0];
      end
    end
  end

endmodule

// File: rtl/stream_mux_nto1.sv
// N:1 streaming multiplexer with packet lock and one registered output stage.
//   clk, rst_n  : rising-edge clock, synchronous active-low reset
//   bus         : stream_mux_nto1_if slave modport (control, inputs, output stream)
//   dbg_state   : grant state (OPEN / LOCKED)
//   dbg_lock_ch : channel holding the lock
//   dbg_rr_ptr  : last channel that finished a packet (round-robin pointer)
// Grant is combinational: the locked channel while mid-packet, else sel (manual)
// or the rotating search (round-robin). Only the granted channel sees in_ready.
module stream_mux_nto1
  import stream_mux_pkg::*;
#(
  parameter  int N_CH   = 4,
  parameter  int DATA_W = 8,
  localparam int SEL_W  = clog2_min1(N_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  stream_mux_nto1_if.slave  bus,
  output mux_state_e        dbg_state,
  output logic [SEL_W-1:0]  dbg_lock_ch,
  output logic [SEL_W-1:0]  dbg_rr_ptr
);

  localparam logic [SEL_W:0] N_CH_X = (SEL_W+1)'(N_CH);

  mux_state_e        state_q;
  logic [SEL_W-1:0]  lock_ch_q;
  logic [SEL_W-1:0]  rr_ptr_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_last_q;
  logic [SEL_W-1:0]  out_ch_q;

  logic              load_en;
  logic              rr_vld;
  logic [SEL_W-1:0]  rr_idx;
  logic              gnt_vld;
  logic [SEL_W-1:0]  gnt_idx;
  logic [N_CH-1:0]   in_ready_w;
  logic              accept;
  logic [DATA_W-1:0] acc_data;
  logic              acc_last;

  rr_arbiter #(.N_CH(N_CH)) u_arb (
    .req     (bus.in_valid),
    .ptr     (rr_ptr_q),
    .gnt_vld (rr_vld),
    .gnt_idx (rr_idx)
  );

  assign load_en = !out_valid_q || bus.out_ready;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    if (state_q == ST_LOCKED) begin
      gnt_vld = 1'b1;
      gnt_idx = lock_ch_q;
    end else if (bus.mode_rr == MODE_RR) begin
      gnt_vld = rr_vld;
      gnt_idx = rr_idx;
    end else if ({1'b0, bus.sel} < N_CH_X) begin
      gnt_vld = 1'b1;
      gnt_idx = bus.sel;
    end
  end

  // Ready fans out to the granted channel only; the same loop picks its beat.
  always_comb begin
    in_ready_w = '0;
    acc_data   = '0;
    acc_last   = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (gnt_idx == SEL_W'(i)) begin
        in_ready_w[i] = rst_n && gnt_vld && load_en;
        acc_data      = bus.in_data[i*DATA_W +: DATA_W];
        acc_last      = bus.in_last[i];
      end
    end
  end

  assign accept = |(in_ready_w & bus.in_valid);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_OPEN;
      lock_ch_q   <= '0;
      rr_ptr_q    <= SEL_W'(N_CH - 1);
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_ch_q    <= '0;
    end else begin
      if (load_en) begin
        out_valid_q <= accept;
        if (accept) begin
          out_data_q <= acc_data;
          out_last_q <= acc_last;
          out_ch_q   <= gnt_idx;
        end
      end
      if (accept) begin
        if (acc_last) begin
          state_q  <= ST_OPEN;
          rr_ptr_q <= gnt_idx;
        end else begin
          state_q   <= ST_LOCKED;
          lock_ch_q <= gnt_idx;
        end
      end
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_ch    = out_ch_q;

  assign dbg_state   = state_q;
  assign dbg_lock_ch = lock_ch_q;
  assign dbg_rr_ptr  = rr_ptr_q;

endmodule

// File: tb/tb_stream_mux_nto1.sv
// Bench for stream_mux_nto1: a 4-channel instance driven through directed steps and a
// randomized phase, plus a 3-channel instance exercising the out-of-range select.
module tb_stream_mux_nto1;
  import stream_mux_pkg::*;

  typedef struct packed {
    logic [1:0] ch;
    logic       last;
    logic [7:0] data;
  } beat_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  stream_mux_nto1_if #(.N_CH(4), .DATA_W(8)) bus_a ();
  stream_mux_nto1_if #(.N_CH(3), .DATA_W(8)) bus_b ();

  mux_state_e dbg_state_a, dbg_state_b;
  logic [1:0] dbg_lock_ch_a, dbg_rr_ptr_a, dbg_lock_ch_b, dbg_rr_ptr_b;

  stream_mux_nto1 #(.N_CH(4), .DATA_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a),
    .dbg_state(dbg_state_a), .dbg_lock_ch(dbg_lock_ch_a), .dbg_rr_ptr(dbg_rr_ptr_a)
  );

  stream_mux_nto1 #(.N_CH(3), .DATA_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b),
    .dbg_state(dbg_state_b), .dbg_lock_ch(dbg_lock_ch_b), .dbg_rr_ptr(dbg_rr_ptr_b)
  );

  // ---------------- scoreboard / reference model ----------------
  int    tests_run    = 0;
  int    tests_failed = 0;
  beat_t exp_q[$];
  beat_t log_q[$];

  bit    m_lock;
  int    m_lock_ch;
  int    m_ptr;
  bit    m_ov;
  bit    mb_ov;
  beat_t mb_beat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Which channel the 4-channel mux should be serving right now (-1 = nobody).
  function automatic int model_grant();
    if (m_lock) return m_lock_ch;
    if (bus_a.mode_rr) begin
      for (int k = 1; k <= 4; k++) begin
        int c;
        c = (m_ptr + k) % 4;
        if (bus_a.in_valid[c]) return c;
      end
      return -1;
    end
    return int'(bus_a.sel);
  endfunction

  // One clock: check against the model mid-cycle, then advance model at the edge.
  task automatic tick();
    int         g, sb;
    bit         load, acc, out_hs, b_acc;
    logic [3:0] er;
    logic [2:0] ebr;
    beat_t      obs, na, nb;
    @(negedge clk);
    g    = model_grant();
    load = !m_ov || (bus_a.out_ready === 1'b1);
    er   = '0;
    if (rst_n && g >= 0 && load) er[g] = 1'b1;
    chk("a_in_ready", bus_a.in_ready, er);
    chk("a_out_valid", bus_a.out_valid, m_ov);
    chk("a_state", dbg_state_a, m_lock ? 1 : 0);
    chk("a_rr_ptr", dbg_rr_ptr_a, m_ptr);
    obs = {bus_a.out_ch, bus_a.out_last, bus_a.out_data};
    if (bus_a.out_valid === 1'b1) begin
      chk("a_sb_depth", exp_q.size(), 1);
      if (exp_q.size() > 0) chk("a_out_beat", obs, exp_q[0]);
    end
    out_hs = (bus_a.out_valid === 1'b1) && (bus_a.out_ready === 1'b1);
    acc = 1'b0;
    na  = '0;
    if (er != 4'b0) begin
      acc = (bus_a.in_valid[g] === 1'b1);
      na  = {2'(g), bus_a.in_last[g], bus_a.in_data[g*8 +: 8]};
    end
    sb  = int'(bus_b.sel);
    ebr = '0;
    if (rst_n && sb < 3) ebr[sb] = 1'b1;
    chk("b_in_ready", bus_b.in_ready, ebr);
    chk("b_out_valid", bus_b.out_valid, mb_ov);
    if (mb_ov) chk("b_out_beat", {bus_b.out_ch, bus_b.out_last, bus_b.out_data}, mb_beat);
    b_acc = 1'b0;
    nb    = '0;
    if (rst_n && sb < 3) begin
      b_acc = (bus_b.in_valid[sb] === 1'b1);
      nb    = {2'(sb), bus_b.in_last[sb], bus_b.in_data[sb*8 +: 8]};
    end
    @(posedge clk);
    if (!rst_n) begin
      m_lock = 1'b0;
      m_ptr  = 3;
      m_ov   = 1'b0;
      mb_ov  = 1'b0;
      exp_q.delete();
    end else begin
      if (out_hs) begin
        log_q.push_back(obs);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      if (load) m_ov = acc;
      if (acc) begin
        exp_q.push_back(na);
        if (na.last) begin
          m_lock = 1'b0;
          m_ptr  = g;
        end else begin
          m_lock    = 1'b1;
          m_lock_ch = g;
        end
      end
      mb_ov = b_acc;
      if (b_acc) mb_beat = nb;
    end
    #1;
  endtask

  // ---------------- driver helpers ----------------
  task automatic drive_a(input logic [3:0] v, input logic [3:0] l);
    bus_a.in_valid = v;
    bus_a.in_last  = l;
    bus_a.in_data  = $urandom;
  endtask

  task automatic chk_log_ch(input string tag, input int n, input int exp_ch[8]);
    chk({tag, "_len"}, log_q.size(), n);
    for (int i = 0; i < n && i < log_q.size(); i++)
      chk($sformatf("%s_ch%0d", tag, i), log_q[i].ch, exp_ch[i]);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int rr_all[8]  = '{0, 1, 2, 3, 0, 1, 2, 3};
    int rr_no2[8]  = '{0, 1, 3, 0, 1, 3, 0, 0};
    int man_ch[8]  = '{0, 1, 2, 3, 0, 0, 0, 0};
    int lock_ch[8] = '{1, 1, 1, 3, 0, 0, 0, 0};
    int bp_ch[8]   = '{0, 1, 2, 3, 0, 0, 0, 0};
    logic [7:0] man_data[4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    m_lock = 1'b0; m_lock_ch = 0; m_ptr = 3; m_ov = 1'b0; mb_ov = 1'b0; mb_beat = '0;

    // Reset with every channel requesting.
    rst_n = 1'b0;
    bus_a.mode_rr = MODE_RR;  bus_a.sel = 2'd0; bus_a.out_ready = 1'b1;
    drive_a(4'b1111, 4'b1111);
    bus_b.mode_rr = MODE_MANUAL; bus_b.sel = 2'd3; bus_b.out_ready = 1'b1;
    bus_b.in_valid = 3'b111; bus_b.in_last = 3'b111; bus_b.in_data = 24'($urandom);
    @(posedge clk); #1;
    tick(); tick();
    chk("rst_out_ch", bus_a.out_ch, 0);
    chk("rst_out_valid", bus_a.out_valid, 0);
    rst_n = 1'b1;
    #1;
    chk("rst_first_grant", bus_a.in_ready, 4'b0001);

    // Round-robin over all channels, then with ch2 idle.
    log_q.delete();
    for (int i = 0; i < 9; i++) begin drive_a(4'b1111, 4'b1111); tick(); end
    chk_log_ch("rr_all", 8, rr_all);
    log_q.delete();
    for (int i = 0; i < 6; i++) begin drive_a(4'b1011, 4'b1111); tick(); end
    chk_log_ch("rr_no2", 6, rr_no2);

    // Manual select with fixed per-channel data.
    bus_a.mode_rr  = MODE_MANUAL;
    bus_a.in_valid = 4'b1111;
    bus_a.in_last  = 4'b1111;
    bus_a.in_data  = {man_data[3], man_data[2], man_data[1], man_data[0]};
    bus_a.sel = 2'd0; tick();
    log_q.delete();
    bus_a.sel = 2'd1; tick();
    bus_a.sel = 2'd2; tick();
    bus_a.sel = 2'd3; tick();
    bus_a.in_valid = 4'b0000; tick();
    chk_log_ch("man", 4, man_ch);
    for (int i = 0; i < 4 && i < log_q.size(); i++)
      chk($sformatf("man_data%0d", i), log_q[i].data, man_data[i]);

    // Three-beat packet on ch1 while ch0/ch3 wait; mode/sel toggled mid-packet.
    log_q.delete();
    bus_a.mode_rr = MODE_MANUAL; bus_a.sel = 2'd1;
    drive_a(4'b1011, 4'b1101); tick();
    bus_a.mode_rr = MODE_RR; bus_a.sel = 2'd0;
    drive_a(4'b1001, 4'b1101); tick();
    drive_a(4'b1011, 4'b1101); tick();
    bus_a.mode_rr = MODE_MANUAL; bus_a.sel = 2'd3;
    drive_a(4'b1011, 4'b1111); tick();
    bus_a.mode_rr = MODE_RR;
    drive_a(4'b1001, 4'b1111); tick();
    drive_a(4'b0000, 4'b1111); tick();
    chk_log_ch("lock", 4, lock_ch);
    if (log_q.size() >= 4) begin
      chk("lock_last0", log_q[0].last, 0);
      chk("lock_last1", log_q[1].last, 0);
      chk("lock_last2", log_q[2].last, 1);
    end

    // Backpressure: output held for 5 clocks, then released.
    bus_a.out_ready = 1'b0;
    drive_a(4'b1111, 4'b1111); tick();
    for (int i = 0; i < 5; i++) begin
      drive_a(4'b1111, 4'b1111);
      tick();
      chk("bp_in_ready", bus_a.in_ready, 4'b0000);
    end
    log_q.delete();
    bus_a.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin drive_a(4'b1111, 4'b1111); tick(); end
    drive_a(4'b0000, 4'b1111); tick();
    chk_log_ch("bp", 5, bp_ch);

    // Reset in the middle of a packet on ch2.
    bus_a.mode_rr = MODE_MANUAL; bus_a.sel = 2'd2;
    drive_a(4'b1111, 4'b1011); tick();
    drive_a(4'b1111, 4'b1011); tick();
    chk("midpkt_locked", dbg_state_a, ST_LOCKED);
    rst_n = 1'b0; tick();
    rst_n = 1'b1;
    log_q.delete();
    bus_a.sel = 2'd0;
    drive_a(4'b1111, 4'b1111); tick();
    drive_a(4'b0000, 4'b1111); tick();
    chk("midpkt_len", log_q.size(), 1);
    if (log_q.size() > 0) chk("midpkt_ch", log_q[0].ch, 0);

    // 3-channel instance: a legal select after the idle out-of-range period.
    bus_b.sel = 2'd2; bus_b.in_data = 24'($urandom); tick(); tick();
    bus_b.sel = 2'd3; tick();

    // Randomized traffic, including occasional resets.
    for (int i = 0; i < 400; i++) begin
      rst_n           = ($urandom_range(0, 60) != 0);
      bus_a.mode_rr   = 1'($urandom_range(0, 1));
      bus_a.sel       = 2'($urandom_range(0, 3));
      bus_a.out_ready = ($urandom_range(0, 3) != 0);
      drive_a(4'($urandom), 4'($urandom));
      bus_b.sel       = 2'($urandom_range(0, 3));
      bus_b.in_valid  = 3'($urandom);
      bus_b.in_last   = 3'b111;
      bus_b.in_data   = 24'($urandom);
      tick();
    end

    rst_n = 1'b1;
    bus_a.out_ready = 1'b1;
    drive_a(4'b0000, 4'b0000);
    bus_b.in_valid = 3'b000;
    tick(); tick(); tick();
    chk("drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Hard time bound in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
